// File: rtl/floppy_bank_if.sv
// ---------------------------------------------------------------------------
// floppy_bank_if
// Write port of the floppy stepper bank.
//   wr        one-cycle write strobe
//   wr_chan   target channel (values >= CHANNELS are ignored by the bank)
//   wr_enable channel enable value written
//   wr_setp   half-period setpoint written
// Modports: master (register controller side), slave (bank side).
// ---------------------------------------------------------------------------
interface floppy_bank_if #(
  parameter int CHANNELS = 8,
  parameter int SP_WIDTH = 22
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr;
  logic [CW-1:0]       wr_chan;
  logic                wr_enable;
  logic [SP_WIDTH-1:0] wr_setp;

  modport master (output wr, wr_chan, wr_enable, wr_setp);
  modport slave  (input  wr, wr_chan, wr_enable, wr_setp);
endinterface

// File: rtl/floppy_bank.sv
// ---------------------------------------------------------------------------
// floppy_bank
// Multi-channel floppy stepper engine. Each channel toggles its step output
// every (active setpoint + 1) cycles while enabled, tracks head position and
// reverses direction automatically at track 0 and track TRACKS-1.
// Setpoint changes on a running channel are held in a shadow register and
// only adopted at a toggle, so no half-period is ever truncated.
//
// Optional feature macro: FLOPPY_BANK_HOME_EN
//   defined   : after reset all drives are stepped toward track 0 for TRACKS
//               full steps (busy=1), then the bank enters normal running.
//   undefined : no homing logic, busy is constantly 0.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   wr_if  write port (floppy_bank_if.slave)
//   step   per-channel step outputs
//   dir    per-channel direction, 1 = toward track TRACKS-1
//   sel    per-channel drive select, active low
//   busy   homing in progress
// ---------------------------------------------------------------------------
module floppy_bank #(
  parameter int CHANNELS = 8,
  parameter int SP_WIDTH = 22,
  parameter int TRACKS   = 80,
  parameter int HOME_DIV = 150000
) (
  input  logic                clk,
  input  logic                rst_n,
  floppy_bank_if.slave        wr_if,
  output logic [CHANNELS-1:0] step,
  output logic [CHANNELS-1:0] dir,
  output logic [CHANNELS-1:0] sel,
  output logic                busy
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (TRACKS > 1) ? $clog2(TRACKS) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(TRACKS - 1);

  // Bank-level homing controls shared by every channel.
  logic busy_w;     // current busy state
  logic busy_nxt;   // busy state after this edge
  logic home_done;  // this edge ends homing
  logic home_step;  // step level all channels take at this edge while homing

`ifdef FLOPPY_BANK_HOME_EN
  localparam int HDW = (HOME_DIV > 1) ? $clog2(HOME_DIV) : 1;
  localparam int TW  = $clog2(2 * TRACKS + 1);
  localparam logic RST_DIR = 1'b0;

  typedef enum logic {ST_HOME, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [HDW-1:0] home_div_q, home_div_d;
  logic [TW-1:0]  home_tog_q, home_tog_d;
  logic           home_step_q, home_step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOME;
      home_div_q  <= '0;
      home_tog_q  <= '0;
      home_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      home_div_q  <= home_div_d;
      home_tog_q  <= home_tog_d;
      home_step_q <= home_step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    home_div_d  = home_div_q;
    home_tog_d  = home_tog_q;
    home_step_d = home_step_q;
    home_done   = 1'b0;
    if (state_q == ST_HOME) begin
      if (home_div_q == HDW'(HOME_DIV - 1)) begin
        home_div_d  = '0;
        home_step_d = ~home_step_q;
        home_tog_d  = home_tog_q + 1'b1;
        // The last of the 2*TRACKS toggles leaves step low and ends homing.
        if (home_tog_q == TW'(2 * TRACKS - 1)) begin
          home_done = 1'b1;
          state_d   = ST_RUN;
        end
      end else begin
        home_div_d = home_div_q + 1'b1;
      end
    end
  end

  assign busy_w    = (state_q == ST_HOME);
  assign busy_nxt  = (state_d == ST_HOME);
  assign home_step = home_step_d;
`else
  localparam logic RST_DIR = 1'b1;
  // HOME_DIV has no effect in this build; busy is permanently low.
  localparam logic HOME_PRESENT = 1'b0 && (HOME_DIV > 0);

  assign busy_w    = HOME_PRESENT;
  assign busy_nxt  = HOME_PRESENT;
  assign home_done = HOME_PRESENT;
  assign home_step = HOME_PRESENT;
`endif

  assign busy = busy_w;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic                en_q, en_d;
      logic [SP_WIDTH-1:0] shadow_q, shadow_d;
      logic [SP_WIDTH-1:0] active_q, active_d;
      logic [SP_WIDTH-1:0] cnt_q, cnt_d;
      logic                step_q, step_d;
      logic                dir_q, dir_d;
      logic [PW-1:0]       pos_q, pos_d;
      logic                sel_q, sel_d;

      logic hit, running, at_top, kill;

      assign hit     = wr_if.wr && (wr_if.wr_chan == CW'(gi));
      assign running = en_q && (active_q != '0) && !busy_w;
      assign at_top  = running && (cnt_q == active_q);
      // A write that disables the channel silences step at the same edge.
      assign kill    = hit && !wr_if.wr_enable;

      always_comb begin
        en_d     = en_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        dir_d    = dir_q;
        pos_d    = pos_q;

        if (hit) begin
          en_d     = wr_if.wr_enable;
          shadow_d = wr_if.wr_setp;
        end

        // Idle channels adopt a write at once; running channels only at a
        // toggle, where a coincident write bypasses the shadow register.
        if (hit && (!running || at_top)) begin
          active_d = wr_if.wr_setp;
        end else if (at_top) begin
          active_d = shadow_q;
        end

        if (home_done) begin
          cnt_d  = '0;
          step_d = 1'b0;
          dir_d  = 1'b1;
          pos_d  = '0;
        end else if (busy_w) begin
          cnt_d  = '0;
          step_d = home_step;
          dir_d  = 1'b0;
        end else if (kill || !running) begin
          cnt_d  = '0;
          step_d = 1'b0;
        end else if (at_top) begin
          cnt_d  = '0;
          step_d = ~step_q;
          if (!step_q) begin
            // Rising step edge moves the head; reaching a limit reverses.
            if (dir_q) begin
              if (pos_q < POS_MAX) pos_d = pos_q + 1'b1;
              if (pos_d == POS_MAX) dir_d = 1'b0;
            end else begin
              if (pos_q != '0) pos_d = pos_q - 1'b1;
              if (pos_d == '0) dir_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        sel_d = ~(en_d | busy_nxt);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_q     <= 1'b0;
          shadow_q <= '0;
          active_q <= '0;
          cnt_q    <= '0;
          step_q   <= 1'b0;
          dir_q    <= RST_DIR;
          pos_q    <= '0;
          sel_q    <= 1'b1;
        end else begin
          en_q     <= en_d;
          shadow_q <= shadow_d;
          active_q <= active_d;
          cnt_q    <= cnt_d;
          step_q   <= step_d;
          dir_q    <= dir_d;
          pos_q    <= pos_d;
          sel_q    <= sel_d;
        end
      end

      assign step[gi] = step_q;
      assign dir[gi]  = dir_q;
      assign sel[gi]  = sel_q;
    end
  endgenerate
endmodule
